fadd_issue: RTL and testbench

- Initiator and collector for the fixed-latency 2-stage `fadd` pipeline.
- Accepts tagged add/sub requests over a valid/ready interface and drives the adder operand buses. It tracks in-flight operations with a latency shift register, captures returning sums into a response FIFO, and presents them with valid/ready.
- Credit-based issue guarantees the FIFO never overflows.
- Sits between the FPU dispatch logic and the `fadd` instance. The adder is instantiated by the parent, not inside this block.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fpu_rsp_fifo.sv | 44 ++++
 rtl/fadd_issue.sv | 74 +++++++
 tb/tb_fadd_issue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op encoding, adder latency and the response record.
package fpu_pkg;
  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
  localparam int   FADD_LAT  = 2;
  localparam int   SIGN_BIT  = 31;
  localparam int   FPU_TAG_W = 5;

  typedef struct packed {
    logic [31:0]          y;
    logic [FPU_TAG_W-1:0] tag;
  } fadd_rsp_t;
endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH, head reads 0 when empty.
module fpu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop & (count != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (pop_ok) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fadd_issue.sv
// Issues tagged add/sub ops to an external fixed-latency fadd and collects
// results in order; credits cover in-flight plus buffered so push never stalls.
module fadd_issue
  import fpu_pkg::*;
#(
  parameter int LAT   = FADD_LAT,
  parameter int DEPTH = 4,
  parameter int TAG_W = FPU_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fa_x1,
  output logic [31:0]      fa_x2,
  input  logic [31:0]      fa_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [LAT-1:0]            vpipe;
  logic [LAT-1:0][TAG_W-1:0] tpipe;
  logic [CW-1:0]             fifo_count;
  logic [31+TAG_W:0]         head;
  logic                      fire;
  int                        inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < LAT; i++) if (vpipe[i]) inflight++;
  end

  // Ready uses the pre-pop count, so there is no ready-to-ready path.
  assign req_ready = rstn & ((inflight + int'(fifo_count)) < DEPTH);
  assign fire      = req_valid & req_ready;
  assign fa_x1     = fire ? req_x1 : '0;
  assign fa_x2     = fire ? {req_x2[SIGN_BIT] ^ (req_op == OP_SUB), req_x2[SIGN_BIT-1:0]} : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
      tpipe <= '0;
    end else begin
      vpipe[0] <= fire;
      tpipe[0] <= req_tag;
      for (int i = 1; i < LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        tpipe[i] <= tpipe[i-1];
      end
    end
  end

  fpu_rsp_fifo #(.DEPTH(DEPTH), .W(32 + TAG_W)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (vpipe[LAT-1]),
    .din   ({fa_y, tpipe[LAT-1]}),
    .pop   (rsp_valid & rsp_ready),
    .head  (head),
    .count (fifo_count)
  );

  assign rsp_valid        = fifo_count != '0;
  assign {rsp_y, rsp_tag} = head;
  assign busy             = (inflight != 0) | rsp_valid;
endmodule

// File: tb/tb_fadd_issue.sv
// Bench for fadd_issue: integer-valued float adder model, queue-based reference,
// per-cycle compare plus directed literal checks.
module tb_fadd_issue;
  localparam int LAT = 2, DEPTH = 4, TAG_W = 5;

  logic             clk = 0, rstn = 0;
  logic             req_valid = 0, req_op = 0, rsp_ready = 0;
  logic [31:0]      req_x1 = 0, req_x2 = 0;
  logic [TAG_W-1:0] req_tag = 0;
  logic [31:0]      fa_x1, fa_x2, fa_y, rsp_y, add_s1;
  logic             req_ready, rsp_valid, busy;
  logic [TAG_W-1:0] rsp_tag;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  fadd_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_tag(rsp_tag), .busy(busy)
  );

  // Exact for integer-valued floats below 2^24 in magnitude.
  function automatic int f2i(input logic [31:0] b);
    int e; longint m, v;
    e = int'(b[30:23]);
    if (e == 0) return 0;
    m = longint'({1'b1, b[22:0]});
    v = (e >= 150) ? (m <<< (e - 150)) : (m >>> (150 - e));
    return b[31] ? -int'(v) : int'(v);
  endfunction

  function automatic logic [31:0] i2f(input int v);
    longint a; int p; logic [31:0] mant; logic [7:0] e;
    if (v == 0) return 32'h0;
    a = (v < 0) ? -longint'(v) : longint'(v);
    p = 0;
    for (int i = 0; i < 40; i++) if (a[i]) p = i;
    mant = (p > 23) ? 32'(a >> (p - 23)) : 32'(a << (23 - p));
    e = 8'(p + 127);
    return {v < 0, e, mant[22:0]};
  endfunction

  function automatic logic [31:0] ref_y(input logic [31:0] x1, x2, input logic op);
    return i2f(f2i(x1) + (op ? -f2i(x2) : f2i(x2)));
  endfunction

  // External two-stage adder owned by the parent.
  always @(posedge clk) begin
    add_s1 <= i2f(f2i(fa_x1) + f2i(fa_x2));
    fa_y   <= add_s1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: every accepted op is outstanding until popped; visible once LAT edges old.
  typedef struct { logic [31:0] y; logic [TAG_W-1:0] tag; int rdy; } ent_t;
  ent_t q[$];

  function automatic bit head_vis();
    return (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
    end else begin
      automatic int  sz   = q.size();
      automatic bit  fire = req_valid && (sz < DEPTH);
      if (head_vis() && rsp_ready) void'(q.pop_front());
      cyc++;
      if (fire) q.push_back('{ref_y(req_x1, req_x2, req_op), req_tag, cyc + LAT});
    end
  end

  always @(negedge clk) begin
    automatic bit ready_e = rstn && (q.size() < DEPTH);
    automatic bit fire_e  = ready_e && req_valid;
    chk("req_ready", 64'(req_ready), 64'(ready_e));
    chk("rsp_valid", 64'(rsp_valid), 64'(rstn && head_vis()));
    chk("busy", 64'(busy), 64'(rstn && q.size() != 0));
    chk("fa_x1", 64'(fa_x1), fire_e ? 64'(req_x1) : 64'h0);
    chk("fa_x2", 64'(fa_x2), fire_e ? 64'({req_x2[31] ^ req_op, req_x2[30:0]}) : 64'h0);
    if (rstn && head_vis()) begin
      chk("rsp_y", 64'(rsp_y), 64'(q[0].y));
      chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
    end else if (!rstn) begin
      chk("rsp_y_rst", 64'(rsp_y), 64'h0);
      chk("rsp_tag_rst", 64'(rsp_tag), 64'h0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic single(input logic [31:0] x1, x2, input logic op, input logic [TAG_W-1:0] tag,
                        input logic [31:0] e_fa2, e_y);
    req_valid = 1; req_x1 = x1; req_x2 = x2; req_op = op; req_tag = tag;
    @(negedge clk);
    chk("single_acc", 64'(req_ready), 64'h1);
    chk("single_fa2", 64'(fa_x2), 64'(e_fa2));
    step(); req_valid = 0;
    @(negedge clk); chk("lat_k", 64'(rsp_valid), 64'h0);
    @(negedge clk); chk("lat_k1", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    chk("lat_k2", 64'(rsp_valid), 64'h1);
    chk("single_y", 64'(rsp_y), 64'(e_y));
    chk("single_tag", 64'(rsp_tag), 64'(tag));
    step();
  endtask

  function automatic logic [31:0] rnd_f();
    return i2f(int'($urandom_range(0, 8000)) - 4000);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nacc;
    int wait_n;
    // model pins
    chk("pin_i2f", 64'(i2f(3)), 64'h40400000);
    chk("pin_f2i", 64'(f2i(32'hC0A00000)), 64'(-5));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_fa", 64'({fa_x1, fa_x2}), 64'h0);
    step(); rstn = 1; #1;
    chk("rel_ready", 64'(req_ready), 64'h1);
    rsp_ready = 1;

    single(32'h3F800000, 32'h40000000, 1'b0, 5'd3, 32'h40000000, 32'h40400000);
    single(32'h40400000, 32'h3F800000, 1'b1, 5'd7, 32'hBF800000, 32'h40000000);
    single(32'h40A00000, 32'h00000000, 1'b0, 5'd9, 32'h00000000, 32'h40A00000);

    // backpressure
    rsp_ready = 0; nacc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_tag = TAG_W'(i); req_x1 = rnd_f(); req_x2 = rnd_f(); req_op = i[0];
      @(negedge clk); if (req_ready) nacc++;
      step();
    end
    req_valid = 0;
    chk("bp_accepted", 64'(nacc), 64'd4);
    @(negedge clk); chk("bp_full", 64'(req_ready), 64'h0);
    step(); rsp_ready = 1;
    @(negedge clk);
    chk("bp_prepop", 64'(req_ready), 64'h0);
    chk("bp_tag0", 64'(rsp_tag), 64'd0);
    for (int t = 1; t < 4; t++) begin
      @(negedge clk);
      if (t == 1) chk("bp_ready_back", 64'(req_ready), 64'h1);
      chk("bp_tag", 64'(rsp_tag), 64'(t));
    end
    step();

    // streaming
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; req_tag = TAG_W'(i + 10); req_x1 = rnd_f(); req_x2 = rnd_f(); req_op = $urandom_range(0, 1);
      @(negedge clk);
      chk("st_ready", 64'(req_ready), 64'h1);
      chk("st_valid", 64'(rsp_valid), 64'(i >= 3));
      step();
    end
    req_valid = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); chk("st_tail", 64'(rsp_valid), 64'(j < 3));
    end
    chk("st_idle", 64'(busy), 64'h0);
    step();

    // reset mid-operation: 1 buffered, 2 in flight
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_tag = TAG_W'(20 + i); req_x1 = rnd_f(); req_x2 = rnd_f();
      step();
    end
    req_valid = 1; req_x1 = 32'h3F800000; req_x2 = 32'h3F800000;
    rstn = 0; #1;
    chk("mid_valid", 64'(rsp_valid), 64'h0);
    chk("mid_busy", 64'(busy), 64'h0);
    chk("mid_fa", 64'({fa_x1, fa_x2}), 64'h0);
    req_valid = 0; rsp_ready = 1;
    step(); rstn = 1; #1;
    chk("mid_ready", 64'(req_ready), 64'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("mid_stale", 64'(rsp_valid), 64'h0);
    end
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = $urandom_range(0, 1);
      req_op    = $urandom_range(0, 1);
      req_tag   = TAG_W'($urandom);
      req_x1    = rnd_f();
      req_x2    = rnd_f();
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 0; rsp_ready = 1;
    wait_n = 0;
    while (busy && wait_n < 20) begin step(); wait_n++; end
    chk("drain", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
